// File: rtl/swipt_pkg.sv
// rtl/swipt_pkg.sv - shared widths, state encoding and arithmetic helpers for the SWIPT phase generator
package swipt_pkg;

  localparam int PER_W_DEF  = 16;
  localparam int DUTY_W_DEF = 10;
  localparam int DEF_PERIOD = 1312;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    RUN  = 2'd2
  } swipt_state_t;

  function automatic logic [31:0] clamp_lo(input logic [31:0] v, input logic [31:0] lo);
    return (v < lo) ? lo : v;
  endfunction

  function automatic logic [31:0] clamp_hi(input logic [31:0] v, input logic [31:0] hi);
    return (v > hi) ? hi : v;
  endfunction

  // on = (p*d) >> duty_w, never longer than the period itself
  function automatic logic [31:0] on_cycles(input logic [31:0] p, input logic [31:0] d,
                                            input int duty_w);
    logic [63:0] prod;
    prod = ({32'd0, p} * {32'd0, d}) >> duty_w;
    return clamp_hi(prod[31:0], p);
  endfunction

  function automatic logic [31:0] phase_off(input logic [31:0] p, input logic [31:0] k,
                                            input int lg_n);
    logic [63:0] prod;
    prod = ({32'd0, p} * {32'd0, k}) >> lg_n;
    return prod[31:0];
  endfunction

  function automatic logic [31:0] phase_preset(input logic [31:0] p, input logic [31:0] off);
    return (off == 32'd0) ? 32'd0 : p - off;
  endfunction

endpackage

// File: rtl/swipt_phase_gen_if.sv
// rtl/swipt_phase_gen_if.sv - configuration handshake between duty-adjust logic and the phase generator
interface swipt_phase_gen_if
  import swipt_pkg::*;
#(
  parameter int PER_W  = PER_W_DEF,
  parameter int DUTY_W = DUTY_W_DEF
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [PER_W-1:0]  cfg_period;
  logic [DUTY_W-1:0] cfg_duty;

  modport master (output cfg_valid, output cfg_period, output cfg_duty, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_period, input cfg_duty, output cfg_ready);
endinterface

// File: rtl/swipt_phase_chan.sv
// rtl/swipt_phase_chan.sv - one output phase: period counter with preset, dead-time window and output flop
module swipt_phase_chan
  import swipt_pkg::*;
#(
  parameter int PER_W    = PER_W_DEF,
  parameter int DEAD_CYC = 2
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             i_load,
  input  logic             i_run,
  input  logic [PER_W-1:0] i_period,
  input  logic [PER_W-1:0] i_on,
  input  logic [PER_W-1:0] i_ld_period,
  input  logic [PER_W-1:0] i_ld_off,
  output logic [PER_W-1:0] o_cnt,
  output logic             o_out
);
  localparam logic [PER_W-1:0] DEAD = PER_W'(DEAD_CYC);
  localparam logic [PER_W-1:0] ONE  = PER_W'(1);

  logic [PER_W-1:0] r_cnt;
  logic             r_out;
  logic             w_in_window;

  assign w_in_window = (r_cnt >= DEAD) && (r_cnt < i_on);

  // load wins over counting so a period boundary can re-phase every channel at once
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_cnt <= '0;
      r_out <= 1'b0;
    end else begin
      if (i_load) begin
        r_cnt <= PER_W'(phase_preset(32'(i_ld_period), 32'(i_ld_off)));
      end else if (i_run) begin
        r_cnt <= (r_cnt == i_period - ONE) ? '0 : r_cnt + ONE;
      end
      r_out <= i_run && w_in_window;
    end
  end

  assign o_cnt = r_cnt;
  assign o_out = r_out;

endmodule

// File: rtl/swipt_phase_gen.sv
// rtl/swipt_phase_gen.sv - multi-phase dead-time-protected SWIPT drive with boundary-aligned config apply
// Optional soft start ramp: define SWIPT_SOFT_START_EN.
module swipt_phase_gen #(
  parameter int NUM_PHASES = 4,
  parameter int PER_W      = swipt_pkg::PER_W_DEF,
  parameter int DUTY_W     = swipt_pkg::DUTY_W_DEF,
  parameter int DUTY_MAX   = 512,
  parameter int MIN_PERIOD = 8,
  parameter int DEF_PERIOD = swipt_pkg::DEF_PERIOD,
  parameter int DEAD_CYC   = 2
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  swipt_phase_gen_if.slave      cfg,
  output logic [NUM_PHASES-1:0] swipt_out,
  output logic                  period_tick,
  output logic [PER_W-1:0]      act_period,
  output logic [PER_W-1:0]      act_on
);
  import swipt_pkg::*;

  localparam int               LG_N = $clog2(NUM_PHASES);
  localparam logic [PER_W-1:0] ONE  = PER_W'(1);

  swipt_state_t     r_state;
  swipt_state_t     w_state_nxt;
  logic             r_pending;
  logic             r_tick;
  logic [PER_W-1:0] r_sh_period;
  logic [PER_W-1:0] r_sh_on;
  logic [PER_W-1:0] r_act_period;
  logic [PER_W-1:0] r_act_on;
  logic [PER_W-1:0] r_sh_off  [NUM_PHASES];
  logic [PER_W-1:0] r_act_off [NUM_PHASES];
  logic [PER_W-1:0] w_cap_off [NUM_PHASES];
  logic [PER_W-1:0] w_cnt     [NUM_PHASES];
  logic [PER_W-1:0] w_cap_period;
  logic [PER_W-1:0] w_cap_on;
  logic [PER_W-1:0] w_ld_period;
  logic [DUTY_W:0]  w_cap_duty;
  logic             w_cap;
  logic             w_running;
  logic             w_wrap0;
  logic             w_apply;
  logic             w_load;

  assign w_cap        = cfg.cfg_valid && cfg.cfg_ready;
  assign w_cap_period = PER_W'(clamp_lo(32'(cfg.cfg_period), MIN_PERIOD));
  assign w_cap_duty   = (DUTY_W+1)'(clamp_hi(32'(cfg.cfg_duty), DUTY_MAX));
  assign w_cap_on     = PER_W'(on_cycles(32'(w_cap_period), 32'(w_cap_duty), DUTY_W));

  assign w_running = en && (r_state != IDLE);
  assign w_wrap0   = w_running && (w_cnt[0] == r_act_period - ONE);
  // pending is the registered flag, so a capture on the wrap cycle waits for the next wrap
  assign w_apply   = r_pending && ((r_state == IDLE) || w_wrap0);
  assign w_load    = (r_state == IDLE) || w_wrap0;
  assign w_ld_period = w_apply ? r_sh_period : r_act_period;

`ifdef SWIPT_SOFT_START_EN
  localparam logic [DUTY_W:0] RAMP_STEP = (DUTY_W+1)'(2 ** (DUTY_W - 6));

  logic [DUTY_W:0] r_sh_duty;
  logic [DUTY_W:0] r_act_duty;
  logic [DUTY_W:0] r_eff_duty;
  logic [DUTY_W:0] w_ld_duty;
  logic [DUTY_W:0] w_eff_sum;
  logic [DUTY_W:0] w_eff_nxt;
  logic            w_ramp_done;

  assign w_ld_duty   = w_apply ? r_sh_duty : r_act_duty;
  assign w_eff_sum   = r_eff_duty + RAMP_STEP;
  assign w_eff_nxt   = (w_eff_sum > w_ld_duty) ? w_ld_duty : w_eff_sum;
  assign w_ramp_done = (w_eff_nxt == w_ld_duty);
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (en) begin
`ifdef SWIPT_SOFT_START_EN
          w_state_nxt = RAMP;
`else
          w_state_nxt = RUN;
`endif
        end
      end
      RAMP: begin
        if (!en) begin
          w_state_nxt = IDLE;
        end
`ifdef SWIPT_SOFT_START_EN
        else if (w_wrap0 && w_ramp_done) begin
          w_state_nxt = RUN;
        end
`endif
      end
      RUN: begin
        if (!en) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_pending    <= 1'b0;
      r_tick       <= 1'b0;
      r_sh_period  <= PER_W'(DEF_PERIOD);
      r_sh_on      <= '0;
      r_act_period <= PER_W'(DEF_PERIOD);
      r_act_on     <= '0;
      for (int k = 0; k < NUM_PHASES; k++) begin
        r_sh_off[k]  <= '0;
        r_act_off[k] <= PER_W'(phase_off(32'(DEF_PERIOD), 32'(k), LG_N));
      end
`ifdef SWIPT_SOFT_START_EN
      r_sh_duty  <= '0;
      r_act_duty <= '0;
      r_eff_duty <= '0;
`endif
    end else begin
      r_tick <= w_running && (w_cnt[0] == '0);

      if (w_cap) begin
        r_pending   <= 1'b1;
        r_sh_period <= w_cap_period;
        r_sh_on     <= w_cap_on;
        for (int k = 0; k < NUM_PHASES; k++) begin
          r_sh_off[k] <= w_cap_off[k];
        end
      end else if (w_apply) begin
        r_pending <= 1'b0;
      end

      if (w_apply) begin
        r_act_period <= r_sh_period;
        for (int k = 0; k < NUM_PHASES; k++) begin
          r_act_off[k] <= r_sh_off[k];
        end
      end

`ifdef SWIPT_SOFT_START_EN
      if (w_cap) begin
        r_sh_duty <= w_cap_duty;
      end
      if (w_apply) begin
        r_act_duty <= r_sh_duty;
      end
      // during the ramp a newly applied config only moves the target duty
      if ((r_state == IDLE) && en) begin
        r_eff_duty <= '0;
        r_act_on   <= '0;
      end else if ((r_state == RAMP) && w_wrap0) begin
        r_eff_duty <= w_eff_nxt;
        r_act_on   <= PER_W'(on_cycles(32'(w_ld_period), 32'(w_eff_nxt), DUTY_W));
      end else if (w_apply) begin
        r_act_on <= r_sh_on;
      end
`else
      if (w_apply) begin
        r_act_on <= r_sh_on;
      end
`endif
    end
  end

  for (genvar k = 0; k < NUM_PHASES; k++) begin : g_ph
    logic [PER_W-1:0] w_ld_off;

    assign w_cap_off[k] = PER_W'(phase_off(32'(w_cap_period), 32'(k), LG_N));
    assign w_ld_off     = w_apply ? r_sh_off[k] : r_act_off[k];

    swipt_phase_chan #(
      .PER_W    (PER_W),
      .DEAD_CYC (DEAD_CYC)
    ) u_chan (
      .clk         (clk),
      .nrst        (nrst),
      .i_load      (w_load),
      .i_run       (w_running),
      .i_period    (r_act_period),
      .i_on        (r_act_on),
      .i_ld_period (w_ld_period),
      .i_ld_off    (w_ld_off),
      .o_cnt       (w_cnt[k]),
      .o_out       (swipt_out[k])
    );
  end

  assign cfg.cfg_ready = !r_pending;
  assign period_tick   = r_tick;
  assign act_period    = r_act_period;
  assign act_on        = r_act_on;

endmodule

// File: tb/tb_swipt_phase_gen.sv
// tb/tb_swipt_phase_gen.sv - directed self-checking bench for swipt_phase_gen (default build)
module tb_swipt_phase_gen;
  localparam int NP = 4;
  localparam int PW = 16;
  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          en = 1'b0;
  logic [NP-1:0] swipt_out;
  logic          period_tick;
  logic [PW-1:0] act_period;
  logic [PW-1:0] act_on;
  logic [NP-1:0] seen_out;
  int            n_checks = 0;
  int            n_errors = 0;
  int            n;

  always #5 clk = ~clk;

  swipt_phase_gen_if #(.PER_W(PW), .DUTY_W(DW)) cfg_if ();

  swipt_phase_gen #(.NUM_PHASES(NP), .PER_W(PW), .DUTY_W(DW)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .en          (en),
    .cfg         (cfg_if),
    .swipt_out   (swipt_out),
    .period_tick (period_tick),
    .act_period  (act_period),
    .act_on      (act_on)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_tick(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      seen_out = seen_out | swipt_out;
    end while (!period_tick && cnt < 5000);
  endtask

  // Starts on a tick cycle; checks one full period against the phase-window model.
  task automatic check_window(input string tag, input int p, input int on, input int exp_high0);
    int mism;
    int high0;
    int ph;
    logic [NP-1:0] exp_v;
    mism  = 0;
    high0 = 0;
    for (int j = 0; j < p; j++) begin
      for (int k = 0; k < NP; k++) begin
        ph = ((j - (p * k) / NP) % p + p) % p;
        exp_v[k] = (ph >= 2) && (ph < on);
      end
      if (swipt_out !== exp_v) mism++;
      if (swipt_out[0] === 1'b1) high0++;
      @(negedge clk);
    end
    check({tag, "_mism"}, mism, 0);
    check({tag, "_high0"}, high0, exp_high0);
    check({tag, "_tick_end"}, period_tick, 1);
  endtask

  task automatic drive_cfg(input int p, input int d);
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_period = PW'(p);
    cfg_if.cfg_duty   = DW'(d);
  endtask

  initial begin
    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_period = '0;
    cfg_if.cfg_duty   = '0;
    seen_out          = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", cfg_if.cfg_ready, 1);
    check("rst_period", act_period, 1312);
    check("rst_on", act_on, 0);
    check("rst_out", swipt_out, 0);
    check("rst_tick", period_tick, 0);
    nrst = 1'b1;
    @(negedge clk);

    // default config running: ticks only, outputs stay low
    en = 1'b1;
    wait_tick(n);
    check("t1_first_tick", n, 2);
    wait_tick(n);
    check("t1_interval", n, 1312);
    check("t1_out_low", seen_out, 0);

    // config while running, applied at the next wrap
    drive_cfg(100, 512);
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    check("t2_ready_low", cfg_if.cfg_ready, 0);
    wait_tick(n);
    check("t2_apply_tick", n, 1311);
    check("t2_period", act_period, 100);
    check("t2_on", act_on, 50);
    check("t2_ready_back", cfg_if.cfg_ready, 1);
    check_window("t2", 100, 50, 48);

    // clamps: period up to 8, duty down to 512
    drive_cfg(4, 900);
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    wait_tick(n);
    check("t3_apply_tick", n, 99);
    check("t3_period", act_period, 8);
    check("t3_on", act_on, 4);
    check_window("t3", 8, 4, 2);

    // back-to-back configs: second waits for the first to apply
    drive_cfg(40, 256);
    @(negedge clk);
    check("t4_ready_low", cfg_if.cfg_ready, 0);
    drive_cfg(64, 1023);
    n = 1;
    while (!cfg_if.cfg_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t4_ready_wait", n, 7);
    check("t4_a_period", act_period, 40);
    check("t4_a_on", act_on, 10);
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    check("t4_b_captured", cfg_if.cfg_ready, 0);
    check("t4_tick_a", period_tick, 1);
    wait_tick(n);
    check("t4_b_tick", n, 40);
    check("t4_b_period", act_period, 64);
    check("t4_b_on", act_on, 32);
    check_window("t4", 64, 32, 30);

    // en dropped mid-pulse, then reasserted
    repeat (10) @(negedge clk);
    check("t5_mid_pulse", swipt_out[0], 1);
    en = 1'b0;
    @(negedge clk);
    check("t5_drop", swipt_out, 0);
    repeat (5) @(negedge clk);
    check("t5_idle_out", swipt_out, 0);
    check("t5_idle_tick", period_tick, 0);
    en = 1'b1;
    wait_tick(n);
    check("t5_restart_tick", n, 2);
    check_window("t5", 64, 32, 30);

    // async reset with a pending config discards it
    drive_cfg(200, 512);
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    en = 1'b0;
    check("t6_pending", cfg_if.cfg_ready, 0);
    #2 nrst = 1'b0;
    #1;
    check("t6_async_period", act_period, 1312);
    check("t6_async_ready", cfg_if.cfg_ready, 1);
    check("t6_async_out", swipt_out, 0);
    @(negedge clk);
    nrst = 1'b1;
    repeat (4) @(negedge clk);
    check("t6_dropped", act_period, 1312);

    // IDLE apply on the cycle after capture; on-time equal to dead time keeps outputs low
    drive_cfg(20, 110);
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    check("t7_ready_low", cfg_if.cfg_ready, 0);
    check("t7_not_yet", act_period, 1312);
    @(negedge clk);
    check("t7_period", act_period, 20);
    check("t7_on", act_on, 2);
    check("t7_ready", cfg_if.cfg_ready, 1);
    en = 1'b1;
    seen_out = '0;
    wait_tick(n);
    check("t7_first_tick", n, 2);
    wait_tick(n);
    check("t7_interval", n, 20);
    check("t7_dead_low", seen_out, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
